hazard_pattern_decoder: RTL
===========================

HAZARD_PATTERN_DECODER -- requirements
Module: hazard_pattern_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 3, the number of consecutive same-class transitions needed to lock; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: clock; all flops update on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tick, input, 1 bit: one-cycle strobe marking that lights holds a new pattern step.
REQ-005 SHALL have port lights, input, 3 bits: observed lamp pattern, possibly asynchronous, bit2 = left lamp.
REQ-006 SHALL have port mode, output, 2 bits: decoded mode; 00 NONE, 01 CALM, 10 RIGHT, 11 LEFT.
REQ-007 SHALL have port locked, output, 1 bit: high while mode is confirmed.
REQ-008 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal pattern or illegal transition.

Function
REQ-009 SHALL pass lights and tick together through a 2-flop synchronizer, so both stay aligned; all decoding uses the synchronized copies.
REQ-010 SHALL treat only 101, 010, 100 and 001 as legal patterns; any other value is illegal.
REQ-011 SHALL classify the transition from the previous legal pattern to the current one as follows.
- CALM: 101->010 or 010->101.
- RIGHT: 100->010, 010->001 or 001->100.
- LEFT: 001->010, 010->100 or 100->001.
- Any other pair, including a repeated pattern, is illegal.
REQ-012 SHALL run an FSM with states IDLE, ACQUIRE and LOCKED, which advances only on a synchronized tick and holds otherwise.
REQ-013 IDLE SHALL behave as follows.
- Legal pattern: store it as prev, clear cand and count, go to ACQUIRE.
- Illegal pattern: pulse err and stay in IDLE.
REQ-014 ACQUIRE SHALL behave as follows on a tick.
- Class equals cand: increment count.
- Class is legal but differs from cand: set cand to the class and count to 1.
- When count reaches LOCK_COUNT: go to LOCKED with mode set to cand.
REQ-015 LOCKED SHALL behave as follows on a tick.
- Class equals mode: stay in LOCKED.
- Class is legal but different: go to ACQUIRE with cand set to the class and count to 1, and deassert locked.
REQ-016 SHALL handle an illegal transition in ACQUIRE or LOCKED as follows.
- Pulse err.
- If the current pattern is legal: store it as prev, clear cand and count, go to ACQUIRE.
- Otherwise: go to IDLE.
REQ-017 SHALL update prev to the current pattern on every tick that carries a legal pattern.
REQ-018 SHALL drive mode = 00 whenever locked = 0; mode and locked SHALL come directly from registers.
REQ-019 SHALL have a latency of 2 clocks from the sampling edge of tick to the updated outputs.
- tick sampled at edge N; outputs change after edge N+2.
- Same latency for err.
REQ-020 SHALL saturate count at LOCK_COUNT; count width SHALL be 4 bits.
REQ-021 With LOCK_COUNT = 1, a single legal transition SHALL lock.
REQ-022 Back-to-back ticks on consecutive cycles SHALL each be processed with no loss.

Reset
REQ-023 While reset is high, SHALL force mode = 00, locked = 0, err = 0, state = IDLE, count = 0, cand = NONE, and clear the synchronizer flops.
REQ-024 Reset asserted mid-ACQUIRE or mid-LOCKED SHALL take effect at the next edge and discard all history.
REQ-025 Ticks already in the synchronizer when reset is asserted SHALL be discarded.

Structure
REQ-026 SHALL place the mode enum, the FSM state enum and the four legal-pattern constants in a shared package, hazard_pkg.
REQ-027 SHALL implement the synchronizer as one sub-module, sync2, parameterized by width and instantiated once at width 4 ({tick, lights}).
REQ-028 SHALL keep transition classification as combinational logic inside hazard_pattern_decoder.

Verification
REQ-029 Reset: hold reset for 2 clocks -> mode = 00, locked = 0, err = 0 for the whole reset and the first idle cycles.
REQ-030 Calm lock: ticks with 101, 010, 101, 010 -> locked = 1 and mode = 01 exactly 2 clocks after the 4th tick; mode = 00 before that.
REQ-031 Right lock then switch to left: ticks with 100, 010, 001, 100 -> mode = 10.
- Then ticks with 001 (a legal LEFT step from 100) -> locked drops 2 clocks after that tick.
- Then 010, 100 -> mode = 11.
REQ-032 Illegal pattern: while locked, tick with 111 -> err high for exactly 1 cycle, locked = 0, mode = 00.
- A following tick with 101 -> state ACQUIRE, no err.
REQ-033 Repeated pattern and no-tick hold: ticks with 010, 010 -> err pulse on the 2nd tick; no tick for 20 clocks -> all outputs hold.
REQ-034 Reset mid-acquire: after 2 calm transitions, assert reset 1 clock -> 3 further calm transitions are needed to lock again.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared mode/state enums and the four legal lamp patterns.
package hazard_pkg;
    typedef enum logic [1:0] {M_NONE, M_CALM, M_RIGHT, M_LEFT} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;
    localparam logic [2:0] PAT_BOTH  = 3'b101;
    localparam logic [2:0] PAT_MID   = 3'b010;
    localparam logic [2:0] PAT_LEFT  = 3'b100;
    localparam logic [2:0] PAT_RIGHT = 3'b001;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a W-bit bus, cleared by synchronous reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk)
        if (reset) {q, meta} <= '0;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/hazard_pattern_decoder.sv
// hazard_pattern_decoder: classifies lamp-pattern transitions and locks onto
// a mode after LOCK_COUNT consecutive same-class transitions.
module hazard_pattern_decoder
    import hazard_pkg::*;
#(
    parameter int LOCK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] lights,
    output logic [1:0] mode,
    output logic       locked,
    output logic       err
);
    localparam logic [3:0] LC = 4'(LOCK_COUNT);
    logic [3:0] s;
    sync2 #(.W(4)) u_sync (.clk(clk), .reset(reset), .d({tick, lights}), .q(s));
    logic       s_tick, legal, cls_ok, locked_n, err_n;
    logic [2:0] pat, prev, prev_n;
    logic [3:0] count, count_n, count_inc;
    state_t     state, state_n;
    mode_t      cand, cand_n, mode_r, mode_n, cls;
    assign s_tick    = s[3];
    assign pat       = s[2:0];
    assign legal     = pat inside {PAT_BOTH, PAT_MID, PAT_LEFT, PAT_RIGHT};
    assign count_inc = (count >= LC) ? LC : count + 4'd1;
    assign mode      = mode_r;
    always_comb begin
        cls    = M_NONE;
        cls_ok = 1'b1;
        if ((prev == PAT_BOTH && pat == PAT_MID) || (prev == PAT_MID && pat == PAT_BOTH))
            cls = M_CALM;
        else if ((prev == PAT_LEFT && pat == PAT_MID) || (prev == PAT_MID && pat == PAT_RIGHT) ||
                 (prev == PAT_RIGHT && pat == PAT_LEFT))
            cls = M_RIGHT;
        else if ((prev == PAT_RIGHT && pat == PAT_MID) || (prev == PAT_MID && pat == PAT_LEFT) ||
                 (prev == PAT_LEFT && pat == PAT_RIGHT))
            cls = M_LEFT;
        else
            cls_ok = 1'b0;
    end
    always_comb begin
        state_n  = state;
        prev_n   = prev;
        cand_n   = cand;
        count_n  = count;
        mode_n   = mode_r;
        locked_n = locked;
        err_n    = 1'b0;
        if (s_tick) begin
            if (legal) prev_n = pat;
            if (state == S_IDLE) begin
                if (legal) begin
                    cand_n  = M_NONE;
                    count_n = '0;
                    state_n = S_ACQUIRE;
                end else err_n = 1'b1;
            end else if (!cls_ok) begin
                // any broken transition drops the lock and restarts from this pattern
                err_n    = 1'b1;
                cand_n   = M_NONE;
                count_n  = '0;
                mode_n   = M_NONE;
                locked_n = 1'b0;
                state_n  = legal ? S_ACQUIRE : S_IDLE;
            end else if (state == S_LOCKED) begin
                if (cls != mode_r) begin
                    cand_n   = cls;
                    count_n  = 4'd1;
                    mode_n   = M_NONE;
                    locked_n = 1'b0;
                    state_n  = S_ACQUIRE;
                end
            end else begin
                cand_n  = cls;
                count_n = (cls == cand) ? count_inc : 4'd1;
                if (count_n >= LC) begin
                    mode_n   = cls;
                    locked_n = 1'b1;
                    state_n  = S_LOCKED;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            prev   <= '0;
            cand   <= M_NONE;
            count  <= '0;
            mode_r <= M_NONE;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            prev   <= prev_n;
            cand   <= cand_n;
            count  <= count_n;
            mode_r <= mode_n;
            locked <= locked_n;
            err    <= err_n;
        end
    end
endmodule
